enc_frame_tx: RTL and testbench

Output framer directly downstream of the encrypter. It captures one encrypted 80-bit payload and its 8-bit CRC per transaction, then emits them as a 13-byte framed stream: sync, sequence number, 10 payload bytes, CRC. The stream uses a valid/ready byte interface toward the link or UART layer. It is the first clocked stage after the combinational encryption path.

---
 rtl/enc_link_pkg.sv | 27 ++
 rtl/enc_frame_tx_if.sv | 44 ++++
 rtl/frame_byte_sel.sv | 32 +++
 rtl/enc_frame_tx.sv | 151 +++++++++++++++
 tb/tb_enc_frame_tx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_link_pkg.sv
// Shared constants, state encoding and helpers for the encrypter output link.
// The frame register holds the 80-bit payload followed by the 8-bit CRC.
package enc_link_pkg;

    localparam int unsigned FRAME_BYTES   = 13;
    localparam int unsigned PAYLOAD_BYTES = 10;
    localparam int unsigned PAYLOAD_W     = 80;
    localparam int unsigned CRC_W         = 8;
    localparam int unsigned FRAME_REG_W   = 88;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        PAYLOAD,
        CRC,
        GAP
    } state_e;

    // States in which a frame byte is being offered downstream.
    function automatic logic is_tx_state(input state_e s);
        return (s == SYNC) || (s == SEQ) || (s == PAYLOAD) || (s == CRC);
    endfunction

endpackage

// File: rtl/enc_frame_tx_if.sv
// Bundle of the payload-capture handshake, byte-stream handshake and status lines.
// master is the framer's view; slave is the surrounding encrypter/link side.
interface enc_frame_tx_if;

    logic        enc_valid;
    logic        enc_ready;
    logic [0:79] enc_data;
    logic [0:7]  enc_crc;

    logic        tx_valid;
    logic        tx_ready;
    logic [0:7]  tx_data;
    logic        tx_last;

    logic        busy;
    logic [0:7]  seq_num;

    modport master (
        input  enc_valid,
        input  enc_data,
        input  enc_crc,
        input  tx_ready,
        output enc_ready,
        output tx_valid,
        output tx_data,
        output tx_last,
        output busy,
        output seq_num
    );

    modport slave (
        output enc_valid,
        output enc_data,
        output enc_crc,
        output tx_ready,
        input  enc_ready,
        input  tx_valid,
        input  tx_data,
        input  tx_last,
        input  busy,
        input  seq_num
    );

endinterface

// File: rtl/frame_byte_sel.sv
// Combinational selection of the frame byte to transmit for a given state and byte index.
// Outside the transmitting states the selected byte is zero.
module frame_byte_sel
    import enc_link_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  state_e                 i_state,
    input  logic [3:0]             i_idx,
    input  logic [0:FRAME_REG_W-1] i_frame,
    input  logic [0:7]             i_seq,
    output logic [0:7]             o_byte
);

    always_comb begin
        o_byte = 8'h00;
        unique case (i_state)
            SYNC:    o_byte = SYNC_BYTE;
            SEQ:     o_byte = i_seq;
            PAYLOAD: begin
                for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
                    if (i_idx == 4'(k)) begin
                        o_byte = i_frame[8*k +: 8];
                    end
                end
            end
            CRC:     o_byte = i_frame[PAYLOAD_W +: CRC_W];
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/enc_frame_tx.sv
// Framer: captures one encrypted payload + CRC and streams sync, sequence number,
// ten payload bytes and CRC over a registered valid/ready byte interface.
module enc_frame_tx
    import enc_link_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    enc_frame_tx_if.master bus
);

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e                 r_state;
    state_e                 w_state_d;
    logic [3:0]             r_idx;
    logic [3:0]             w_idx_d;
    logic [3:0]             r_gap;
    logic [3:0]             w_gap_d;
    logic [0:FRAME_REG_W-1] r_frame;
    logic [0:FRAME_REG_W-1] w_frame_d;
    logic [0:7]             r_seq;
    logic [0:7]             w_seq_d;
    logic [0:7]             r_seq_lat;
    logic [0:7]             w_seq_lat_d;

    logic                   r_rdy_en;
    logic                   r_tx_valid;
    logic                   r_tx_last;
    logic [0:7]             r_tx_data;
    logic [0:7]             w_tx_byte;

    logic                   w_enc_ready;
    logic                   w_capture;
    logic                   w_accept;

    // Held low through reset and released one clock later, so enc_ready never
    // depends on enc_valid or on the reset pin combinationally.
    assign w_enc_ready = r_rdy_en && (r_state == IDLE);
    assign w_capture   = bus.enc_valid && w_enc_ready;
    assign w_accept    = r_tx_valid && bus.tx_ready;

    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_gap_d     = r_gap;
        w_frame_d   = r_frame;
        w_seq_d     = r_seq;
        w_seq_lat_d = r_seq_lat;
        unique case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_d   = SYNC;
                    w_frame_d   = {bus.enc_data, bus.enc_crc};
                    w_seq_lat_d = r_seq;
                    w_seq_d     = r_seq + 8'd1;
                    w_idx_d     = 4'd0;
                end
            end
            SYNC: begin
                if (w_accept) begin
                    w_state_d = SEQ;
                end
            end
            SEQ: begin
                if (w_accept) begin
                    w_state_d = PAYLOAD;
                    w_idx_d   = 4'd0;
                end
            end
            PAYLOAD: begin
                if (w_accept) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_d = CRC;
                        w_idx_d   = 4'd0;
                    end else begin
                        w_idx_d = r_idx + 4'd1;
                    end
                end
            end
            CRC: begin
                if (w_accept) begin
                    w_gap_d = 4'd0;
                    if (GAP_CYCLES > 0) begin
                        w_state_d = GAP;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_d = IDLE;
                    w_gap_d   = 4'd0;
                end else begin
                    w_gap_d = r_gap + 4'd1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Output byte is chosen from next-state values and then registered, so
    // tx_data never sees tx_ready through a combinational path.
    frame_byte_sel #(
        .SYNC_BYTE(SYNC_BYTE)
    ) u_byte_sel (
        .i_state(w_state_d),
        .i_idx  (w_idx_d),
        .i_frame(w_frame_d),
        .i_seq  (w_seq_lat_d),
        .o_byte (w_tx_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= 4'd0;
            r_gap      <= 4'd0;
            r_frame    <= '0;
            r_seq      <= 8'h00;
            r_seq_lat  <= 8'h00;
            r_rdy_en   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_state_d;
            r_idx      <= w_idx_d;
            r_gap      <= w_gap_d;
            r_frame    <= w_frame_d;
            r_seq      <= w_seq_d;
            r_seq_lat  <= w_seq_lat_d;
            r_rdy_en   <= 1'b1;
            r_tx_valid <= is_tx_state(w_state_d);
            r_tx_last  <= (w_state_d == CRC);
            r_tx_data  <= w_tx_byte;
        end
    end

    assign bus.enc_ready = w_enc_ready;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_last   = r_tx_last;
    assign bus.busy      = (r_state != IDLE);
    assign bus.seq_num   = r_seq;

endmodule

// File: tb/tb_enc_frame_tx.sv
// Directed + randomized bench for enc_frame_tx; frames are predicted from the
// framing rules (sync, frame count mod 256, payload bytes MSB first, CRC).
module tb_enc_frame_tx;

    localparam logic [7:0]  SYNC_B = 8'hA5;
    localparam int unsigned GAP    = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   m_frames;

    enc_frame_tx_if bus ();

    enc_frame_tx #(
        .SYNC_BYTE (SYNC_B),
        .GAP_CYCLES(GAP)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:79] rand80();
        logic [0:79] v;
        v = {$urandom(), $urandom(), 16'($urandom())};
        return v;
    endfunction

    // Asserts reset at the current time, checks the asynchronous reset values,
    // then releases on a falling edge and checks enc_ready comes up.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_tx_valid", 104'(bus.tx_valid), 104'd0);
        check("rst_busy", 104'(bus.busy), 104'd0);
        check("rst_tx_data", 104'(bus.tx_data), 104'd0);
        check("rst_tx_last", 104'(bus.tx_last), 104'd0);
        check("rst_seq_num", 104'(bus.seq_num), 104'd0);
        check("rst_enc_ready", 104'(bus.enc_ready), 104'd0);
        bus.enc_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_enc_ready", 104'(bus.enc_ready), 104'd1);
        m_frames = 0;
    endtask

    task automatic capture(input logic [0:79] d, input logic [0:7] c, input bit hold,
                           input bit scramble, output bit ok);
        ok = 1'b0;
        bus.enc_data  = d;
        bus.enc_crc   = c;
        bus.enc_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.enc_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("capture_timeout", 104'd0, 104'd1);
        end else begin
            @(posedge clk);
            #1;
            if (!hold) bus.enc_valid = 1'b0;
            if (scramble) begin
                bus.enc_data = rand80();
                bus.enc_crc  = 8'($urandom());
            end
            @(negedge clk);
        end
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0 repeating; 2: random ready.
    task automatic collect(input int mode, input int limit, input bit scramble,
                           output logic [0:103] f, output int nbytes, output int cycles);
        bit         done;
        bit         pend;
        logic [0:8] pend_v;
        logic       rdy;
        f      = '0;
        nbytes = 0;
        cycles = 0;
        done   = 1'b0;
        pend   = 1'b0;
        pend_v = '0;
        for (int c = 0; c < 400 && nbytes < limit && !done; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((c % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.tx_ready = rdy;
            if (scramble) begin
                bus.enc_data = rand80();
                bus.enc_crc  = 8'($urandom());
            end
            if (pend) begin
                check("stall_valid_held", 104'(bus.tx_valid), 104'd1);
                check("stall_data_held", 104'({bus.tx_data, bus.tx_last}), 104'(pend_v));
            end
            if (bus.tx_valid === 1'b1 && rdy) begin
                check("tx_last_position", 104'(bus.tx_last), 104'(nbytes == 12));
                f[nbytes*8 +: 8] = bus.tx_data;
                nbytes++;
                if (bus.tx_last === 1'b1) begin
                    done   = 1'b1;
                    cycles = c + 1;
                end
                pend = 1'b0;
            end else if (bus.tx_valid === 1'b1) begin
                pend   = 1'b1;
                pend_v = {bus.tx_data, bus.tx_last};
            end
            @(negedge clk);
        end
        bus.tx_ready = 1'b0;
        if (!done && nbytes < limit) check("collect_timeout", 104'd0, 104'd1);
    endtask

    task automatic send_frame(input logic [0:79] d, input logic [0:7] c, input int mode,
                              input bit hold, input bit scramble,
                              output logic [0:103] f, output int cycles);
        logic [0:103] e;
        bit           ok;
        int           nb;
        e = {SYNC_B, 8'(m_frames % 256), d, c};
        m_frames++;
        f = '0;
        cycles = 0;
        capture(d, c, hold, scramble, ok);
        if (ok) begin
            collect(mode, 13, scramble, f, nb, cycles);
            check("frame_bytes", 104'(nb), 104'd13);
            check("frame_content", f, e);
        end
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.enc_ready === 1'b1) break;
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("gap_timeout", 104'd0, 104'd1);
    endtask

    initial begin
        logic [0:103] f;
        logic [0:79]  d;
        logic [0:79]  d2;
        logic [0:7]   cr;
        int           cyc;
        int           gap_n;
        int           nb;
        bit           ok;

        checks        = 0;
        errors        = 0;
        m_frames      = 0;
        rst_n         = 1'b1;
        bus.enc_valid = 1'b0;
        bus.enc_data  = '0;
        bus.enc_crc   = '0;
        bus.tx_ready  = 1'b0;
        #2;
        do_reset();

        // Basic frame with known payload
        d = 80'h0123456789ABCDEF0011;
        send_frame(d, 8'h5A, 0, 1'b0, 1'b0, f, cyc);
        check("basic_literal", f, 104'hA5_00_0123456789ABCDEF0011_5A);
        check("basic_cycles", 104'(cyc), 104'd13);
        check("basic_seq_num", 104'(bus.seq_num), 104'd1);
        check("gap_busy", 104'(bus.busy), 104'd1);
        check("gap_tx_valid", 104'(bus.tx_valid), 104'd0);
        measure_gap(gap_n);
        check("basic_gap", 104'(gap_n), 104'(GAP));

        // Backpressure with the same payload
        send_frame(d, 8'h5A, 1, 1'b0, 1'b0, f, cyc);
        check("bp_literal", f, 104'hA5_01_0123456789ABCDEF0011_5A);

        // Back-to-back with enc_valid held high
        do_reset();
        d  = rand80();
        d2 = rand80();
        cr = 8'($urandom());
        send_frame(d, cr, 0, 1'b1, 1'b0, f, cyc);
        bus.enc_data = d2;
        bus.enc_crc  = ~cr;
        measure_gap(gap_n);
        check("b2b_gap", 104'(gap_n), 104'(GAP));
        send_frame(d2, ~cr, 0, 1'b0, 1'b0, f, cyc);
        check("b2b_seq_byte", 104'(f[8:15]), 104'h01);

        // Input isolation with random backpressure
        send_frame(rand80(), 8'($urandom()), 2, 1'b0, 1'b1, f, cyc);

        // Reset during payload byte 4
        d = rand80();
        capture(d, 8'($urandom()), 1'b0, 1'b0, ok);
        if (ok) begin
            collect(0, 6, 1'b0, f, nb, cyc);
            check("mid_pre_valid", 104'(bus.tx_valid), 104'd1);
            check("mid_pre_byte4", 104'(bus.tx_data), 104'(d[32:39]));
        end
        do_reset();
        send_frame(rand80(), 8'($urandom()), 0, 1'b0, 1'b0, f, cyc);
        check("mid_restart_hdr", 104'(f[0:15]), 104'hA500);

        // Sequence wrap across 257 frames
        do_reset();
        for (int n = 1; n <= 257; n++) begin
            send_frame(rand80(), 8'($urandom()), (n % 2) * 2, 1'b0, 1'b0, f, cyc);
            if (n == 256) check("wrap_seq_256", 104'(f[8:15]), 104'hFF);
            if (n == 257) check("wrap_seq_257", 104'(f[8:15]), 104'h00);
        end
        check("wrap_seq_num", 104'(bus.seq_num), 104'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
